// File: rtl/divisor_restauracion.sv
// divisor_restauracion: 6-bit by 3-bit restoring divider (control FSM + datapath).
// Rev 1.0
`default_nettype none

module divisor_restauracion (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] dividendo,
  input  logic [2:0] divisor,
  output logic [5:0] cociente,
  output logic [2:0] resto,
  output logic       Fin,
  output logic       ocupado,
  output logic       error_div0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [5:0] q_q, q_d;
  logic [2:0] m_q, m_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] coc_q, coc_d;
  logic [2:0] res_q, res_d;
  logic       err_q, err_d;

  logic [3:0] w_a_sh;
  logic [3:0] w_t;
  logic [3:0] w_a_nx;
  logic [5:0] w_q_nx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= 4'd0;
      q_q     <= 6'd0;
      m_q     <= 3'd0;
      cnt_q   <= 3'd0;
      coc_q   <= 6'd0;
      res_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      coc_q   <= coc_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // One restoring step; a negative trial difference (bit 3) keeps the shifted remainder.
  always_comb begin
    w_a_sh = {a_q[2:0], q_q[5]};
    w_t    = w_a_sh - {1'b0, m_q};
    w_a_nx = w_t[3] ? w_a_sh : w_t;
    w_q_nx = {q_q[4:0], ~w_t[3]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    coc_d   = coc_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != 3'd0) begin
            a_d     = 4'd0;
            q_d     = dividendo;
            m_d     = divisor;
            cnt_d   = 3'd6;
            err_d   = 1'b0;
            state_d = ITER;
          end else begin
            coc_d   = 6'h3F;
            res_d   = 3'd0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      ITER: begin
        a_d   = w_a_nx;
        q_d   = w_q_nx;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          coc_d   = w_q_nx;
          res_d   = w_a_nx[2:0];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cociente   = coc_q;
  assign resto      = res_q;
  assign Fin        = (state_q == DONE);
  assign ocupado    = (state_q != IDLE);
  assign error_div0 = (state_q == DONE) && err_q;

endmodule

`default_nettype wire
